// File: rtl/multdiv_pkg.sv
// Shared definitions for the execute-stage multiply/divide unit: FSM states,
// datapath step modes, default widths and the ALU-op codes that request it.
package multdiv_pkg;

    localparam int WIDTH_DEF = 32;
    localparam int TAG_W_DEF = 5;

    function automatic int cnt_width(input int w);
        return $clog2(w);
    endfunction

    localparam int CNT_W = cnt_width(WIDTH_DEF);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MULT = 2'd1,
        DIV  = 2'd2,
        DONE = 2'd3
    } state_t;

    typedef enum logic {
        MODE_MUL = 1'b0,
        MODE_DIV = 1'b1
    } mode_t;

    // Decode raises start_mult for ALU_MUL and start_div for ALU_DIV.
    typedef enum logic [3:0] {
        ALU_ADD = 4'h0,
        ALU_SUB = 4'h1,
        ALU_AND = 4'h2,
        ALU_OR  = 4'h3,
        ALU_MUL = 4'h8,
        ALU_DIV = 4'h9
    } alu_op_t;

endpackage

// File: rtl/multdiv_if.sv
// Request/response bundle between the decode/execute latch and the
// multiply/divide unit.
interface multdiv_if
    import multdiv_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int TAG_W = TAG_W_DEF
);
    logic             start_mult;
    logic             start_div;
    logic [WIDTH-1:0] A_in;
    logic [WIDTH-1:0] B_in;
    logic [TAG_W-1:0] tag_in;
    logic             busy;
    logic             stall;
    logic [WIDTH-1:0] result;
    logic             result_ready;
    logic             exception;
    logic [TAG_W-1:0] tag_out;

    modport master (
        output start_mult, start_div, A_in, B_in, tag_in,
        input  busy, stall, result, result_ready, exception, tag_out
    );

    modport slave (
        input  start_mult, start_div, A_in, B_in, tag_in,
        output busy, stall, result, result_ready, exception, tag_out
    );
endinterface

// File: rtl/multdiv_iter.sv
// One iteration of the unsigned datapath: shift-add for multiply, restoring
// compare-subtract-shift for divide. {hi, lo} is the shared working register.
module multdiv_iter
    import multdiv_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  mode_t            mode,
    input  logic [WIDTH-1:0] hi,
    input  logic [WIDTH-1:0] lo,
    input  logic [WIDTH-1:0] operand,
    output logic [WIDTH-1:0] hi_nxt,
    output logic [WIDTH-1:0] lo_nxt
);
    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   shifted;
    logic [WIDTH-1:0] diff;

    // NOTE: every output gets a default first so no path can infer a latch.
    always_comb begin
        sum     = '0;
        shifted = '0;
        diff    = '0;
        hi_nxt  = hi;
        lo_nxt  = lo;
        if (mode == MODE_MUL) begin
            // hi accumulates the multiplicand; the carry shifts into hi's MSB.
            sum    = {1'b0, hi} + (lo[0] ? {1'b0, operand} : '0);
            hi_nxt = sum[WIDTH:1];
            lo_nxt = {sum[0], lo[WIDTH-1:1]};
        end else begin
            // hi is the partial remainder, lo shifts dividend out and quotient in.
            shifted = {hi, lo[WIDTH-1]};
            diff    = shifted[WIDTH-1:0] - operand;
            if (shifted >= {1'b0, operand}) begin
                hi_nxt = diff;
                lo_nxt = {lo[WIDTH-2:0], 1'b1};
            end else begin
                hi_nxt = shifted[WIDTH-1:0];
                lo_nxt = {lo[WIDTH-2:0], 1'b0};
            end
        end
    end
endmodule

// File: rtl/multdiv_ctrl.sv
// Multi-cycle signed multiply/divide controller: FSM, iteration counter,
// sign fixup, overflow detection and the held result registers.
module multdiv_ctrl
    import multdiv_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int TAG_W = TAG_W_DEF
) (
    input logic      clock,
    input logic      reset,
    multdiv_if.slave bus
);
    localparam int CW = cnt_width(WIDTH);

    state_t           state, state_nxt;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] hi, lo, op_mag;
    logic [WIDTH-1:0] hi_step, lo_step;
    logic             neg;
    logic [TAG_W-1:0] tag_q;
    logic [WIDTH-1:0] res_q, fix_result;
    logic             exc_q, fix_exc, ready_q, fits;
    logic [TAG_W-1:0] tag_out_q;
    logic             start_any, last_iter, div_zero;
    mode_t            mode;

    function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v);
        return v[WIDTH-1] ? -v : v;
    endfunction

    assign start_any = bus.start_mult | bus.start_div;
    assign last_iter = (cnt == CW'(WIDTH - 1));
    assign div_zero  = (state == DIV) && (op_mag == '0);
    assign mode      = (state == DIV) ? MODE_DIV : MODE_MUL;

    multdiv_iter #(.WIDTH(WIDTH)) u_iter (
        .mode    (mode),
        .hi      (hi),
        .lo      (lo),
        .operand (op_mag),
        .hi_nxt  (hi_step),
        .lo_nxt  (lo_step)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (bus.start_mult)     state_nxt = MULT;
                else if (bus.start_div) state_nxt = DIV;
            end
            MULT:    if (last_iter) state_nxt = DONE;
            DIV:     if (div_zero || last_iter) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Sign fixup on the final step's output, so the result lands on the
    // same edge that enters DONE.
    always_comb begin
        fix_result = '0;
        fix_exc    = 1'b0;
        fits       = 1'b0;
        if (state == MULT) begin
            // A negative product may reach magnitude 2^(WIDTH-1); a positive one may not.
            fits = (hi_step == '0) &&
                   (!lo_step[WIDTH-1] || (neg && (lo_step[WIDTH-2:0] == '0)));
            if (fits) fix_result = neg ? -lo_step : lo_step;
            else      fix_exc    = 1'b1;
        end else if (div_zero) begin
            fix_exc = 1'b1;
        end else if (!neg && lo_step[WIDTH-1]) begin
            fix_exc = 1'b1;
        end else begin
            fix_result = neg ? -lo_step : lo_step;
        end
    end

    // NOTE: state is updated with non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= '0;
            hi        <= '0;
            lo        <= '0;
            op_mag    <= '0;
            neg       <= 1'b0;
            tag_q     <= '0;
            res_q     <= '0;
            exc_q     <= 1'b0;
            ready_q   <= 1'b0;
            tag_out_q <= '0;
        end else begin
            state   <= state_nxt;
            ready_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (start_any) begin
                        cnt   <= '0;
                        hi    <= '0;
                        tag_q <= bus.tag_in;
                        neg   <= bus.A_in[WIDTH-1] ^ bus.B_in[WIDTH-1];
                        if (bus.start_mult) begin
                            lo     <= mag(bus.B_in);
                            op_mag <= mag(bus.A_in);
                        end else begin
                            lo     <= mag(bus.A_in);
                            op_mag <= mag(bus.B_in);
                        end
                    end
                end
                MULT, DIV: begin
                    cnt <= cnt + 1'b1;
                    hi  <= hi_step;
                    lo  <= lo_step;
                    if (state_nxt == DONE) begin
                        res_q     <= fix_result;
                        exc_q     <= fix_exc;
                        tag_out_q <= tag_q;
                        ready_q   <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.busy         = (state == MULT) || (state == DIV);
    assign bus.stall        = bus.busy || ((state == IDLE) && start_any);
    assign bus.result       = res_q;
    assign bus.exception    = exc_q;
    assign bus.result_ready = ready_q;
    assign bus.tag_out      = tag_out_q;
endmodule

// File: tb/tb_multdiv_ctrl.sv
// Directed bench for multdiv_ctrl: an arithmetic reference model checked
// every cycle, plus hand-computed literal expectations per operation.
module tb_multdiv_ctrl;
    import multdiv_pkg::*;

    typedef struct packed {
        logic [31:0] res;
        logic        exc;
    } op_t;

    logic clk;
    logic rst;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    bit   chk_en = 0;

    bit          pend = 0;
    int          pend_cyc = 0;
    op_t         pend_op = '0;
    logic [4:0]  pend_tag = '0;
    op_t         held_op = '0;
    logic [4:0]  held_tag = '0;

    multdiv_if bus ();

    multdiv_ctrl dut (
        .clock (clk),
        .reset (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic op_t model_op(input bit is_mul, input int a, input int b);
        op_t    o;
        longint p;
        o = '0;
        if (is_mul) begin
            p = longint'(a) * longint'(b);
            if (p > 64'sd2147483647 || p < -64'sd2147483648) o.exc = 1'b1;
            else o.res = p[31:0];
        end else if (b == 0) begin
            o.exc = 1'b1;
        end else if (a == int'(32'h8000_0000) && b == -1) begin
            o.exc = 1'b1;
        end else begin
            o.res = a / b;
        end
        return o;
    endfunction

    // Reference model: one accepted operation at a time, result after 33 cycles
    // (2 for a zero divisor), starts ignored while one is outstanding.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rst) begin
            pend     <= 1'b0;
            held_op  <= '0;
            held_tag <= '0;
        end else if (pend) begin
            if (cyc + 1 == pend_cyc) begin
                held_op  <= pend_op;
                held_tag <= pend_tag;
            end
            if (cyc == pend_cyc) pend <= 1'b0;
        end else if (bus.start_mult || bus.start_div) begin
            pend     <= 1'b1;
            pend_op  <= model_op(bus.start_mult, bus.A_in, bus.B_in);
            pend_tag <= bus.tag_in;
            pend_cyc <= cyc + ((!bus.start_mult && bus.B_in == 32'd0) ? 2 : 33);
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("cmp_ready", bus.result_ready, pend && cyc == pend_cyc);
            check("cmp_busy", bus.busy, pend && cyc != pend_cyc);
            check("cmp_stall", bus.stall,
                  (pend && cyc != pend_cyc) || (!pend && (bus.start_mult || bus.start_div)));
            check("cmp_result", bus.result, held_op.res);
            check("cmp_exception", bus.exception, held_op.exc);
            check("cmp_tag", bus.tag_out, held_tag);
        end
    end

    task automatic run_op(input string name, input bit m, input bit d,
                          input logic [31:0] a, input logic [31:0] b, input logic [4:0] t,
                          input logic [31:0] er, input bit ee, input int elat, input int inj);
        int n, lat, pulses;
        lat = -1;
        pulses = 0;
        @(posedge clk); #1;
        bus.start_mult = m;
        bus.start_div  = d;
        bus.A_in       = a;
        bus.B_in       = b;
        bus.tag_in     = t;
        n = cyc;
        @(negedge clk);
        check({name, "_stall_start"}, bus.stall, 1);
        @(posedge clk); #1;
        bus.start_mult = 1'b0;
        bus.start_div  = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (inj > 0) bus.start_div = (cyc - n == inj);
            if (bus.result_ready) begin
                pulses++;
                if (lat < 0) begin
                    lat = cyc - n;
                    check({name, "_result"}, bus.result, er);
                    check({name, "_exception"}, bus.exception, ee);
                    check({name, "_tag"}, bus.tag_out, t);
                    check({name, "_stall_done"}, bus.stall, 0);
                end
            end
        end
        bus.start_div = 1'b0;
        check({name, "_latency"}, lat, elat);
        check({name, "_pulses"}, pulses, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        int n, pulses;
        rst            = 1'b1;
        bus.start_mult = 1'b0;
        bus.start_div  = 1'b0;
        bus.A_in       = '0;
        bus.B_in       = '0;
        bus.tag_in     = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        chk_en = 1'b1;

        @(negedge clk);
        check("reset_busy", bus.busy, 0);
        check("reset_stall", bus.stall, 0);
        check("reset_result", bus.result, 0);
        check("reset_ready", bus.result_ready, 0);
        check("reset_tag", bus.tag_out, 0);

        run_op("mul_7x6",     1, 0, 32'd7,          32'd6,          5'd3,  32'd42,         0, 33, 0);
        run_op("mul_m5x3",    1, 0, -32'sd5,        32'd3,          5'd4,  32'hFFFF_FFF1,  0, 33, 0);
        run_op("mul_ovf",     1, 0, 32'd100000,     32'd100000,     5'd5,  32'd0,          1, 33, 0);
        run_op("mul_minfit",  1, 0, 32'h8000_0000,  32'd1,          5'd6,  32'h8000_0000,  0, 33, 0);
        run_op("mul_negedge", 1, 0, -32'sd65536,    32'd32768,      5'd7,  32'h8000_0000,  0, 33, 0);
        run_op("mul_posovf",  1, 0, 32'd65536,      32'd32768,      5'd8,  32'd0,          1, 33, 0);
        run_op("div_100_7",   0, 1, 32'd100,        32'd7,          5'd9,  32'd14,         0, 33, 0);
        run_op("div_m7_2",    0, 1, -32'sd7,        32'd2,          5'd10, 32'hFFFF_FFFD,  0, 33, 0);
        run_op("div_m100_7",  0, 1, -32'sd100,      32'd7,          5'd11, 32'hFFFF_FFF2,  0, 33, 0);
        run_op("div_by0",     0, 1, 32'd5,          32'd0,          5'd12, 32'd0,          1, 2,  0);
        run_op("div_ovf",     0, 1, 32'h8000_0000,  32'hFFFF_FFFF,  5'd13, 32'd0,          1, 33, 0);
        run_op("both_start",  1, 1, 32'd4,          32'd2,          5'd14, 32'd8,          0, 33, 10);

        // Abort a multiply with reset in its 15th cycle.
        @(posedge clk); #1;
        bus.start_mult = 1'b1;
        bus.A_in       = 32'd9;
        bus.B_in       = 32'd9;
        bus.tag_in     = 5'd15;
        n = cyc;
        @(posedge clk); #1;
        bus.start_mult = 1'b0;
        repeat (14) @(posedge clk);
        #1;
        check("rst_mid_cycle", cyc - n, 15);
        check("rst_busy_before", bus.busy, 1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("rst_mid_busy", bus.busy, 0);
        check("rst_mid_stall", bus.stall, 0);
        check("rst_mid_result", bus.result, 0);
        check("rst_mid_ready", bus.result_ready, 0);
        check("rst_mid_exception", bus.exception, 0);
        check("rst_mid_tag", bus.tag_out, 0);
        pulses = 0;
        repeat (40) begin
            @(negedge clk);
            if (bus.result_ready) pulses++;
        end
        check("rst_mid_no_ready", pulses, 0);

        run_op("mul_3x3",     1, 0, 32'd3,          32'd3,          5'd1,  32'd9,          0, 33, 0);

        repeat (3) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/multdiv_ctrl.md
Name: multdiv_ctrl

Overview:
Multi-cycle multiply/divide unit in the execute stage, fed by the decode/execute latch (pc, instr, A, B).
- Accepts a one-cycle start request for a signed multiply or divide.
- Iterates one bit per cycle and returns a 32-bit result with a completion pulse.
- Drives a stall back to the fetch/decode and decode/execute latches while busy, making it the consuming end of that latch.

Parameters:
WIDTH, 32, operand/result width; iteration count equals WIDTH
TAG_W, 5, destination-register tag width carried with the operation

Ports:
clock  input  1  system clock, rising edge
reset  input  1  synchronous, active-high; clears all state
start_mult  input  1  one-cycle request: result = A_in * B_in (signed)
start_div  input  1  one-cycle request: result = A_in / B_in (signed, truncate toward zero)
A_in  input  WIDTH  operand A from decode/execute latch
B_in  input  WIDTH  operand B from decode/execute latch
tag_in  input  TAG_W  destination register of the requesting instruction
busy  output  1  operation in progress (states MULT, DIV)
stall  output  1  hold upstream latches
result  output  WIDTH  last completed result; held until the next completion
result_ready  output  1  one-cycle pulse on completion
exception  output  1  valid with result_ready; overflow or divide-by-zero
tag_out  output  TAG_W  tag of the completed operation; held with result

Behaviour:
- Clock and reset: one clock domain; reset synchronous, active-high. A reset cycle forces state IDLE, and busy, stall, result, result_ready, exception and tag_out all go to 0.
- States:
  - IDLE: start_mult -> MULT; else start_div -> DIV; else stay. Operands and tag are latched on the start edge.
  - MULT: WIDTH cycles, then DONE.
  - DIV: WIDTH cycles, then DONE. If B == 0, go to DONE the next cycle with no iteration.
  - DONE: one cycle, then IDLE.
- Simultaneous start_mult and start_div: multiply wins; divide is dropped.
- Start requests while in MULT, DIV or DONE are ignored, with no queuing. The upstream stall prevents this in normal use.
- Latency: start sampled in cycle T. result_ready is high in cycle T+WIDTH+1 (T+33 at default). For divide-by-zero it is high in T+2.
  - result, exception and tag_out update on the same edge that raises result_ready.
  - result_ready is low in every other cycle.
- stall is combinational: high in MULT and DIV, and in IDLE when either start is high. It is low in DONE, so the pipeline advances while the result is presented.
- Multiply:
  - Take magnitudes of A and B and run a 2*WIDTH-bit shift-add, one partial product per cycle.
  - Negate the product if the signs differ.
  - result is the low WIDTH bits.
  - exception = 1 if the full signed product does not fit in WIDTH signed bits; result is 0 when exception is set.
- Divide:
  - Restoring division on magnitudes, one quotient bit per cycle.
  - Quotient sign = sign(A) xor sign(B); truncate toward zero; remainder discarded.
  - B == 0: exception = 1, result = 0.
  - A == -2^(WIDTH-1) with B == -1: exception = 1, result = 0.
- Iteration counter counts 0..WIDTH-1 and is cleared on entry to MULT or DIV.
- Reset in mid-operation aborts the operation: no result_ready, outputs cleared.

Decomposition:
- Shared package multdiv_pkg holds:
  - the state encoding (IDLE, MULT, DIV, DONE);
  - the WIDTH default;
  - the ALU-op codes that decode to start_mult and start_div, used by the decode logic that drives the starts;
  - the iteration-count width, clog2(WIDTH).
- One natural sub-module, multdiv_iter. It holds the combinational one-step datapath: a shift-add step for multiply and a compare-subtract-shift step for divide, selected by mode.
- The control FSM, counter, sign fixup and output registers stay in multdiv_ctrl.

Test Plan:
- start_mult, A=7, B=6, tag=3 -> stall high from the start cycle; result_ready exactly 33 cycles later with result=42, exception=0, tag_out=3; stall low in that cycle.
- start_mult, A=-5, B=3 -> result=0xFFFFFFF1 (-15); then A=100000, B=100000 -> exception=1, result=0.
- start_div, A=100, B=7 -> result=14; A=-7, B=2 -> result=-3 (0xFFFFFFFD); both with exception=0 and 33-cycle latency.
- start_div, A=5, B=0 -> result_ready 2 cycles after start, exception=1, result=0; A=0x80000000, B=-1 -> exception=1 after 33 cycles.
- start_mult and start_div together (A=4, B=2) -> result=8. A new start_div pulsed at cycle 10 of the multiply is ignored: exactly one result_ready occurs.
- Reset asserted at cycle 15 of a multiply -> next cycle busy=0, stall=0, result=0, no result_ready. A following start_mult 3*3 completes normally with result=9.
